// File: rtl/pipe_hazard_ctl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctl
//
// Hazard controller for a classic five-stage MIPS-style integer pipeline.
// It owns the EX, MEM and WB instruction registers. Each cycle it decides
// whether the pipeline advances, inserts a bubble into EX, or holds EX/MEM
// while a multi-cycle load occupies the MEM stage. It also selects the
// bypass source for both EX operands.
//
// Parameters
//   REG_AW    register-address width (only 5 is accepted)
//   MEM_LAT   cycles a lw spends in MEM (1..4); 1 means a single-cycle load
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   instr_id   instruction currently in ID
//   stall      freeze PC and IF/ID register (combinational)
//   instr_ex   registered instruction in EX
//   instr_mem  registered instruction in MEM
//   instr_wb   registered instruction in WB
//   fwd_a      EX rs source: 00 regfile, 01 MEM result, 10 WB result
//   fwd_b      EX rt source: 00 regfile, 01 MEM result, 10 WB result
//
// Configuration macro
//   HAZARD_FWD_EN  defined   -> bypassing active, only load-use stalls
//                  undefined -> fwd_a/fwd_b tied to 00, and ID stalls while
//                               any producer of its sources sits in EX or MEM
// ---------------------------------------------------------------------------
module pipe_hazard_ctl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    output logic        stall,
    output logic [31:0] instr_ex,
    output logic [31:0] instr_mem,
    output logic [31:0] instr_wb,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    // Reject configurations this generation does not support.
    if (REG_AW != 5) begin : gBadRegAw
        $error("pipe_hazard_ctl: REG_AW must be 5");
    end
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : gBadMemLat
        $error("pipe_hazard_ctl: MEM_LAT must be in 1..4");
    end

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Extra MEM cycles a load needs beyond the first one.
    localparam logic [1:0] LOAD_CNT = 2'(MEM_LAT - 1);

    typedef logic [REG_AW-1:0] regAddr_t;

    // Register usage of one instruction.
    typedef struct packed {
        logic     wr;
        regAddr_t dst;
        logic     rdRs;
        logic     rdRt;
        regAddr_t rs;
        regAddr_t rt;
        logic     isLoad;
    } decode_t;

    // Pipeline action for the coming clock edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_BUBBLE,
        ACT_HOLD
    } action_t;

    // Extract which registers an instruction reads and writes. Anything that
    // targets $0 is not treated as a writer, which also makes the all-zero
    // word (sll $0,$0,0) a harmless nop.
    function automatic decode_t decode(input logic [31:0] ins);
        decode_t d;
        logic [5:0] op;
        logic [5:0] fn;
        op     = ins[31:26];
        fn     = ins[5:0];
        d      = '0;
        d.rs   = ins[25:21];
        d.rt   = ins[20:16];
        case (op)
            OP_RTYPE: begin
                d.wr   = (fn != FN_JR);
                d.dst  = ins[15:11];
                d.rdRs = (fn != FN_SLL);
                d.rdRt = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_SLT) ||
                         (fn == FN_SLL)  || (fn == FN_XOR);
            end
            OP_LW: begin
                d.wr     = 1'b1;
                d.dst    = ins[20:16];
                d.rdRs   = 1'b1;
                d.isLoad = 1'b1;
            end
            OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI: begin
                d.wr   = 1'b1;
                d.dst  = ins[20:16];
                d.rdRs = 1'b1;
            end
            OP_LUI: begin
                d.wr  = 1'b1;
                d.dst = ins[20:16];
            end
            OP_JAL: begin
                d.wr  = 1'b1;
                d.dst = regAddr_t'(5'd31);
            end
            OP_J: begin
                d.wr = 1'b0;
            end
            OP_SW, OP_BEQ: begin
                d.rdRs = 1'b1;
                d.rdRt = 1'b1;
            end
            default: begin
                d.rdRs = 1'b1;
            end
        endcase
        if (d.dst == '0) begin
            d.wr = 1'b0;
        end
        return d;
    endfunction

    // True when consumer reads the register that producer writes.
    function automatic logic readsDst(input decode_t consumer, input decode_t producer);
        return producer.wr &&
               ((consumer.rdRs && (consumer.rs == producer.dst)) ||
                (consumer.rdRt && (consumer.rt == producer.dst)));
    endfunction

    logic [31:0] r_instrEx;
    logic [31:0] r_instrMem;
    logic [31:0] r_instrWb;
    logic [1:0]  r_memCnt;

    decode_t w_dId;
    decode_t w_dEx;
    decode_t w_dMem;
    logic    w_dataHazard;
    action_t w_action;

    assign w_dId  = decode(instr_id);
    assign w_dEx  = decode(r_instrEx);
    assign w_dMem = decode(r_instrMem);

`ifdef HAZARD_FWD_EN
    decode_t w_dWb;
    assign w_dWb = decode(r_instrWb);

    // Pick the bypass source for one EX operand. The MEM stage is the
    // youngest producer and wins over WB. A load still in MEM has no data
    // yet, so it is skipped; the load-use bubble keeps that case from ever
    // mattering for a real dependency.
    function automatic logic [1:0] fwdSel(input logic srcUsed, input regAddr_t src,
                                          input decode_t memStage, input decode_t wbStage);
        logic [1:0] sel;
        sel = 2'b00;
        if (srcUsed && memStage.wr && !memStage.isLoad && (memStage.dst == src)) begin
            sel = 2'b01;
        end else if (srcUsed && wbStage.wr && (wbStage.dst == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // With bypassing only a load directly ahead of its consumer must stall.
    assign w_dataHazard = w_dEx.isLoad && readsDst(w_dId, w_dEx);
    assign fwd_a        = fwdSel(w_dEx.rdRs, w_dEx.rs, w_dMem, w_dWb);
    assign fwd_b        = fwdSel(w_dEx.rdRt, w_dEx.rt, w_dMem, w_dWb);
`else
    // Without bypassing, ID waits until every producer of its sources has
    // reached WB, where the register file makes the value visible.
    assign w_dataHazard = readsDst(w_dId, w_dEx) || readsDst(w_dId, w_dMem);
    assign fwd_a        = 2'b00;
    assign fwd_b        = 2'b00;
`endif

    // Decide what the pipeline does at the next edge. An outstanding load in
    // MEM freezes EX and MEM outright, so no bubble is inserted during the
    // hold; data hazards are looked at again once the load is released.
    always_comb begin
        w_action = ACT_ADVANCE;
        stall    = 1'b0;
        if (r_memCnt != 2'd0) begin
            w_action = ACT_HOLD;
        end else if (w_dataHazard) begin
            w_action = ACT_BUBBLE;
        end
        stall = (w_action != ACT_ADVANCE);
    end

    // Stage registers and load-latency counter. The counter is loaded each
    // time a lw moves from EX into MEM, whether by a normal advance or
    // alongside a bubble, and counts down the extra MEM cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrEx  <= '0;
            r_instrMem <= '0;
            r_instrWb  <= '0;
            r_memCnt   <= 2'd0;
        end else begin
            case (w_action)
                ACT_HOLD: begin
                    r_instrWb <= '0;
                    r_memCnt  <= r_memCnt - 2'd1;
                end
                ACT_BUBBLE: begin
                    r_instrEx  <= '0;
                    r_instrMem <= r_instrEx;
                    r_instrWb  <= r_instrMem;
                    r_memCnt   <= w_dEx.isLoad ? LOAD_CNT : 2'd0;
                end
                default: begin
                    r_instrEx  <= instr_id;
                    r_instrMem <= r_instrEx;
                    r_instrWb  <= r_instrMem;
                    r_memCnt   <= w_dEx.isLoad ? LOAD_CNT : 2'd0;
                end
            endcase
        end
    end

    assign instr_ex  = r_instrEx;
    assign instr_mem = r_instrMem;
    assign instr_wb  = r_instrWb;

endmodule
